// File: rtl/tcm_arbiter.sv
// Two-master (I fetch / D data) arbiter in front of the single TCM bus port.
// Define TCM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module tcm_arbiter #(
  parameter int AW = 14,
  parameter int DW = 32,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  // instruction-fetch master
  input  logic [AW-1:0] i_addr,
  input  logic          i_w_rb,
  input  logic [CW-1:0] i_acc,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_req,
  output logic [DW-1:0] i_rdata,
  output logic          i_resp,
  output logic          i_fault,
  // data master
  input  logic [AW-1:0] d_addr,
  input  logic          d_w_rb,
  input  logic [CW-1:0] d_acc,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_req,
  output logic [DW-1:0] d_rdata,
  output logic          d_resp,
  output logic          d_fault,
  // TCM controller side
  output logic [AW-1:0] s_addr,
  output logic          s_w_rb,
  output logic [CW-1:0] s_acc,
  output logic [DW-1:0] s_wdata,
  output logic          s_req,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_resp,
  input  logic          s_fault,
  // debug visibility of the arbiter state and current owner (0=I, 1=D)
  output logic [0:0]    dbg_state,
  output logic          dbg_owner
);

  // Handshake: a master raises req with stable fields and holds them until the cycle
  // its resp or fault is high. s_req is a one-cycle offer; s_fault answers in that same
  // cycle, s_resp arrives in any later cycle and completes the outstanding transaction.

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic       OWN_I   = 1'b0;
  localparam logic       OWN_D   = 1'b1;

  logic [0:0] state;
  logic       owner;
  logic       in_wait;
  logic       slot_open;
  logic       elig_i;
  logic       elig_d;
  logic       prefer_i;
  logic       sel_i;
  logic       grant;

`ifdef TCM_ARB_RR_EN
  logic rr_ptr;
  assign prefer_i = (rr_ptr == OWN_I);
`else
  assign prefer_i = 1'b0;
`endif

  always_comb begin
    in_wait   = (state == ST_WAIT);
    // a new grant can go out when idle, or in the very cycle the outstanding one completes
    slot_open = !in_wait || s_resp;
    elig_i    = !rst && i_req && slot_open && !(in_wait && owner == OWN_I);
    elig_d    = !rst && d_req && slot_open && !(in_wait && owner == OWN_D);
    sel_i     = elig_i && (!elig_d || prefer_i);
    grant     = elig_i || elig_d;
  end

  always_comb begin
    s_req   = grant;
    s_addr  = sel_i ? i_addr  : d_addr;
    s_w_rb  = sel_i ? i_w_rb  : d_w_rb;
    s_acc   = sel_i ? i_acc   : d_acc;
    s_wdata = sel_i ? i_wdata : d_wdata;
    i_fault = grant && sel_i && s_fault;
    d_fault = grant && !sel_i && s_fault;
    i_resp  = !rst && in_wait && s_resp && (owner == OWN_I);
    d_resp  = !rst && in_wait && s_resp && (owner == OWN_D);
    i_rdata = s_rdata;
    d_rdata = s_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= OWN_I;
    end else if (grant) begin
      state <= s_fault ? ST_IDLE : ST_WAIT;
      if (!s_fault) owner <= sel_i ? OWN_I : OWN_D;
    end else if (in_wait && s_resp) begin
      state <= ST_IDLE;
    end
  end

`ifdef TCM_ARB_RR_EN
  // the master just granted loses preference for the next contested cycle
  always_ff @(posedge clk) begin
    if (rst)        rr_ptr <= OWN_D;
    else if (grant) rr_ptr <= sel_i ? OWN_D : OWN_I;
  end
`endif

  assign dbg_state = state;
  assign dbg_owner = owner;

endmodule

// File: tb/tb_tcm_arbiter.sv
// Bench for tcm_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (who is outstanding, who may start, who wins).
module tb_tcm_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int CW = 2;
`ifdef TCM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_addr, d_addr, s_addr;
  logic          i_w_rb, d_w_rb, s_w_rb;
  logic [CW-1:0] i_acc, d_acc, s_acc;
  logic [DW-1:0] i_wdata, d_wdata, s_wdata;
  logic          i_req, d_req, s_req;
  logic [DW-1:0] i_rdata, d_rdata, s_rdata;
  logic          i_resp, d_resp, s_resp;
  logic          i_fault, d_fault, s_fault;
  logic [0:0]    dbg_state;
  logic          dbg_owner;

  int total = 0;
  int bad   = 0;
  logic [AW:0] exp_q[$];

  tcm_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_w_rb(i_w_rb), .i_acc(i_acc), .i_wdata(i_wdata), .i_req(i_req),
    .i_rdata(i_rdata), .i_resp(i_resp), .i_fault(i_fault),
    .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc), .d_wdata(d_wdata), .d_req(d_req),
    .d_rdata(d_rdata), .d_resp(d_resp), .d_fault(d_fault),
    .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata), .s_req(s_req),
    .s_rdata(s_rdata), .s_resp(s_resp), .s_fault(s_fault),
    .dbg_state(dbg_state), .dbg_owner(dbg_owner)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = '0; i_w_rb = 0; i_acc = '0; i_wdata = '0;
    d_req = 0; d_addr = '0; d_w_rb = 0; d_acc = '0; d_wdata = '0;
    s_resp = 0; s_fault = 0; s_rdata = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1;
    repeat (2) tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    i_req = 1; d_req = 1; s_resp = 1; s_fault = 1;
    repeat (2) tick();
    total++;
    if ({s_req, i_resp, d_resp, i_fault, d_fault} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 00000", {s_req, i_resp, d_resp, i_fault, d_fault});
    end
    total++;
    if ({dbg_state, dbg_owner} !== 2'b00) begin
      bad++;
      $display("FAIL reset_state: got %b want 00", {dbg_state, dbg_owner});
    end
    clear_inputs();
    tick();
    rst = 0;
  endtask

  task automatic test_single_read();
    logic [DW-1:0] rd;
    rd = $urandom;
    i_req = 1; i_addr = 14'h0010; i_w_rb = 0; i_acc = 2'd2;
    #1;
    total++;
    if ({s_req, s_addr, s_w_rb} !== {1'b1, 14'h0010, 1'b0}) begin
      bad++;
      $display("FAIL single_grant: got req=%b addr=%h want req=1 addr=0010", s_req, s_addr);
    end
    tick();
    s_resp = 1; s_rdata = rd;
    #1;
    total++;
    if ({i_resp, d_resp, i_rdata} !== {1'b1, 1'b0, rd}) begin
      bad++;
      $display("FAIL single_resp: got i=%b d=%b rdata=%h want i=1 d=0 rdata=%h", i_resp, d_resp, i_rdata, rd);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: got %b want 0", dbg_state);
    end
  endtask

  task automatic test_priority();
    i_req = 1; i_addr = 14'h0100;
    d_req = 1; d_addr = 14'h0200; d_w_rb = 1; d_wdata = 32'hCAFE_0001;
    #1;
    total++;
    if ({s_req, s_addr, s_w_rb, s_wdata} !== {1'b1, 14'h0200, 1'b1, 32'hCAFE_0001}) begin
      bad++;
      $display("FAIL prio_first: got req=%b addr=%h want req=1 addr=0200", s_req, s_addr);
    end
    tick();
    s_resp = 1;
    #1;
    total++;
    if ({d_resp, i_resp, s_req, s_addr} !== {1'b1, 1'b0, 1'b1, 14'h0100}) begin
      bad++;
      $display("FAIL prio_b2b: got d=%b i=%b req=%b addr=%h want d=1 i=0 req=1 addr=0100", d_resp, i_resp, s_req, s_addr);
    end
    tick();
    d_req = 0;
    #1;
    total++;
    if ({i_resp, d_resp, s_req} !== 3'b100) begin
      bad++;
      $display("FAIL prio_second: got i=%b d=%b req=%b want 1 0 0", i_resp, d_resp, s_req);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int grants;
    bit  i_done;
    d_req = 1; d_addr = 14'h0004;
    tick();
    s_resp = 1;
    tick();
    clear_inputs();
    // pointer now prefers I
    i_req = 1; i_addr = 14'h0300;
    d_req = 1; d_addr = 14'h0400;
    #1;
    total++;
    if ({s_req, s_addr} !== {1'b1, 14'h0300}) begin
      bad++;
      $display("FAIL rr_first: got req=%b addr=%h want req=1 addr=0300", s_req, s_addr);
    end
    tick();
    s_resp = 1;
    #1;
    total++;
    if ({i_resp, s_req, s_addr} !== {1'b1, 1'b1, 14'h0400}) begin
      bad++;
      $display("FAIL rr_second: got i=%b req=%b addr=%h want i=1 req=1 addr=0400", i_resp, s_req, s_addr);
    end
    tick();
    i_req = 0;
    // D streams continuously with I pending
    tick();
    i_req = 1; i_addr = 14'h0500;
    grants = 0; i_done = 0;
    for (int c = 0; c < 6 && !i_done; c++) begin
      s_resp = 1;
      #1;
      if (s_req) begin
        grants++;
        if (s_addr == 14'h0500) i_done = 1;
      end
      tick();
    end
    total++;
    if (!i_done || grants > 2) begin
      bad++;
      $display("FAIL rr_bound: got i_served=%b grants=%0d want 1 and <=2", i_done, grants);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_fault();
    d_req = 1; d_addr = 14'h0002; d_acc = 2'd2; s_fault = 1;
    #1;
    total++;
    if ({s_req, d_fault, d_resp, i_fault, i_resp} !== 5'b11000) begin
      bad++;
      $display("FAIL fault_same_cycle: got %b want 11000", {s_req, d_fault, d_resp, i_fault, i_resp});
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if ({dbg_state, s_req, d_resp, d_fault} !== 4'b0000) begin
      bad++;
      $display("FAIL fault_idle: got %b want 0000", {dbg_state, s_req, d_resp, d_fault});
    end
  endtask

  task automatic test_slow_resp();
    i_req = 1; i_addr = 14'h0020;
    tick();
    d_req = 1; d_addr = 14'h0040;
    for (int c = 1; c < 3; c++) begin
      #1;
      total++;
      if ({s_req, i_resp, d_resp} !== 3'b000) begin
        bad++;
        $display("FAIL slow_hold%0d: got %b want 000", c, {s_req, i_resp, d_resp});
      end
      tick();
    end
    s_resp = 1;
    #1;
    total++;
    if ({i_resp, d_resp, s_req, s_addr} !== {1'b1, 1'b0, 1'b1, 14'h0040}) begin
      bad++;
      $display("FAIL slow_resp: got i=%b d=%b req=%b addr=%h want 1 0 1 0040", i_resp, d_resp, s_req, s_addr);
    end
    tick();
    i_req = 0;
    #1;
    total++;
    if ({d_resp, i_resp} !== 2'b10) begin
      bad++;
      $display("FAIL slow_d_resp: got %b want 10", {d_resp, i_resp});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_in_wait();
    i_req = 1; i_addr = 14'h0030;
    tick();
    rst = 1;
    #1;
    total++;
    if ({s_req, i_resp, d_resp, i_fault, d_fault} !== 5'b0) begin
      bad++;
      $display("FAIL rstwait_outputs: got %b want 00000", {s_req, i_resp, d_resp, i_fault, d_fault});
    end
    tick();
    rst = 0; i_req = 0; s_resp = 1;
    #1;
    total++;
    if ({i_resp, d_resp, s_req, dbg_state} !== 4'b0000) begin
      bad++;
      $display("FAIL rstwait_spurious: got %b want 0000", {i_resp, d_resp, s_req, dbg_state});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    bit m_busy, m_owner, m_ptr;
    bit i_act, d_act, ci, cd, wi, g, e_ir, e_dr, e_if, e_df, opn;
    logic [AW:0] seen, want;
    apply_reset();
    m_busy = 0; m_owner = 0; m_ptr = 1; i_act = 0; d_act = 0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      if (!i_act) begin
        i_addr = AW'($urandom); i_w_rb = 1'($urandom); i_acc = CW'($urandom); i_wdata = $urandom;
        i_act = ($urandom_range(0, 2) == 0);
      end
      if (!d_act) begin
        d_addr = AW'($urandom); d_w_rb = 1'($urandom); d_acc = CW'($urandom); d_wdata = $urandom;
        d_act = ($urandom_range(0, 2) == 0);
      end
      i_req = i_act; d_req = d_act;
      s_resp = ($urandom_range(0, 2) == 0);
      s_fault = ($urandom_range(0, 6) == 0);
      s_rdata = $urandom;
      // a master may start when nothing is outstanding or the outstanding one finishes now
      opn = !m_busy || s_resp;
      ci = i_act && opn && !(m_busy && m_owner == 1'b0);
      cd = d_act && opn && !(m_busy && m_owner == 1'b1);
      wi = (ci && cd) ? (RR && m_ptr == 1'b0) : ci;
      g = ci || cd;
      e_ir = m_busy && s_resp && m_owner == 1'b0;
      e_dr = m_busy && s_resp && m_owner == 1'b1;
      e_if = g && wi && s_fault;
      e_df = g && !wi && s_fault;
      #1;
      total++;
      if ({s_req, i_resp, d_resp, i_fault, d_fault, dbg_state} !== {g, e_ir, e_dr, e_if, e_df, m_busy}) begin
        bad++;
        $display("FAIL rand_ctrl c=%0d: got %b want %b", c, {s_req, i_resp, d_resp, i_fault, d_fault, dbg_state},
                 {g, e_ir, e_dr, e_if, e_df, m_busy});
      end
      if (g) begin
        total++;
        if ({s_addr, s_w_rb, s_acc, s_wdata} !== (wi ? {i_addr, i_w_rb, i_acc, i_wdata} : {d_addr, d_w_rb, d_acc, d_wdata})) begin
          bad++;
          $display("FAIL rand_mux c=%0d: got addr=%h want winner %s", c, s_addr, wi ? "I" : "D");
        end
      end
      if (i_resp || d_resp) begin
        seen = d_resp ? {1'b1, d_addr} : {1'b0, i_addr};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, {AW{1'b1}}};
        total++;
        if (seen !== want || (d_resp ? d_rdata : i_rdata) !== s_rdata) begin
          bad++;
          $display("FAIL rand_scoreboard c=%0d: got %h want %h", c, seen, want);
        end
      end
      if (g) begin
        if (!s_fault) exp_q.push_back(wi ? {1'b0, i_addr} : {1'b1, d_addr});
        m_busy = !s_fault;
        if (!s_fault) m_owner = !wi;
        m_ptr = wi;
      end else if (m_busy && s_resp) begin
        m_busy = 0;
      end
      if (e_ir || e_if) i_act = 0;
      if (e_dr || e_df) d_act = 0;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_single_read();
`ifdef TCM_ARB_RR_EN
    apply_reset();
    test_round_robin();
`else
    test_priority();
`endif
    test_fault();
    test_slow_resp();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
